// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshakes and an iterative shift-add multiply.
// Non-MUL ops complete in one cycle; MUL holds the pipe via in_ready until its result is ready.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                  state;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH-1:0]        acc;
    logic [WIDTH-1:0]        mcand;
    logic [WIDTH-1:0]        mplier;
    logic [WIDTH-1:0]        acc_next;

    logic                    accept;
    logic                    is_mul;
    logic                    do_sub;
    logic [WIDTH-1:0]        b_op;
    logic [WIDTH:0]          add_full;
    logic signed [WIDTH-1:0] sum;
    logic                    carry;
    logic                    add_ovf;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (Signal == OP_MUL);

    // Shared adder: SUB, SLT and SLTU all compute a + ~b + 1.
    assign do_sub   = (Signal == OP_SUB) || (Signal == OP_SLT) || (Signal == OP_SLTU);
    assign b_op     = do_sub ? ~b : b;
    assign add_full = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, do_sub};
    assign sum      = add_full[WIDTH-1:0];
    assign carry    = add_full[WIDTH];
    assign add_ovf  = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Signal)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  begin alu_res = sum; alu_ovf = add_ovf; end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~carry};
            OP_MUL:  alu_res = '0;
            OP_XOR:  alu_res = a ^ b;
            OP_SUB:  begin alu_res = sum; alu_ovf = add_ovf; end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: alu_res = '0;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state     <= S_MUL;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == WIDTH'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (out_ready) out_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Multiply datapath; qualified by state so it needs no reset
    always_ff @(posedge clk) begin
        if (state == S_IDLE && accept && is_mul) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe at WIDTH=32: arithmetic flags, compares, back-to-back flow,
// iterative multiply timing, output hold/drain, and reset during a multiply.
module tb_alu_pipe;

    localparam int W = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .Signal    (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present one op for a single edge; outputs are sampled 1 time unit after that edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({out_valid, zero, overflow, busy} !== 4'b0000 || result !== '0) begin
            failures++;
            $display("FAIL reset_state: got vld=%b z=%b ovf=%b busy=%b res=%h, need all 0",
                     out_valid, zero, overflow, busy, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_add_overflow;
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin
            failures++;
            $display("FAIL add_ovf: got vld=%b res=%h ovf=%b z=%b need 1 80000000 1 0",
                     out_valid, result, overflow, zero);
        end
        issue(OP_ADD, 32'h0000_1234, 32'h0000_0FFF);
        checks++;
        if (result !== 32'h0000_2233 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL add_plain: got res=%h ovf=%b need 00002233 0", result, overflow);
        end
    endtask

    task automatic test_compare;
        logic [2:0]   ops [5];
        logic [W-1:0] xs  [5];
        logic [W-1:0] ys  [5];
        logic [W-1:0] exp [5];
        ops = '{OP_SLT, OP_SLTU, OP_SLT, OP_SLTU, OP_SLT};
        xs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'h1};
        ys  = '{32'h1, 32'h1, 32'h1, 32'h2, 32'hFFFF_FFFF};
        exp = '{32'h1, 32'h0, 32'h1, 32'h1, 32'h0};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], xs[i], ys[i]);
            checks++;
            if (result !== exp[i] || zero !== (exp[i] == '0) || overflow !== 1'b0) begin
                failures++;
                $display("FAIL compare_%0d: got res=%h z=%b ovf=%b need res=%h z=%b ovf=0",
                         i, result, zero, overflow, exp[i], (exp[i] == '0));
            end
        end
    endtask

    task automatic test_sub;
        issue(OP_SUB, 32'd5, 32'd5);
        checks++;
        if (result !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL sub_zero: got res=%h z=%b ovf=%b need 0 1 0", result, zero, overflow);
        end
        issue(OP_SUB, 32'h8000_0000, 32'h1);
        checks++;
        if (result !== 32'h7FFF_FFFF || overflow !== 1'b1 || zero !== 1'b0) begin
            failures++;
            $display("FAIL sub_ovf: got res=%h ovf=%b z=%b need 7fffffff 1 0", result, overflow, zero);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]   ops [3];
        logic [W-1:0] exp [3];
        ops = '{OP_AND, OP_OR, OP_XOR};
        exp = '{32'hF000_1200, 32'hFFF0_FF34, 32'h0FF0_ED34};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d: got %b need 1", i, in_ready);
            end
            in_valid = 1'b1; op = ops[i]; a = 32'hF0F0_1234; b = 32'hFF00_FF00;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== exp[i]) begin
                failures++;
                $display("FAIL b2b_result_%0d: got vld=%b res=%h need 1 %h", i, out_valid, result, exp[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got vld=%b need 0", out_valid);
        end
    endtask

    task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp, input string name);
        int n;
        int bad;
        n = 0;
        bad = 0;
        issue(OP_MUL, x, y);
        // Offer a competing op while busy; it must be ignored.
        in_valid = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1;
        while (out_valid !== 1'b1 && n < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != W) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles need %0d", name, n, W);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_busy: got %0d cycles without busy/stall need 0", name, bad);
        end
        checks++;
        if (result !== exp || busy !== 1'b0 || overflow !== 1'b0 || zero !== (exp == '0)) begin
            failures++;
            $display("FAIL %s_result: got res=%h busy=%b ovf=%b z=%b need %h 0 0 %b",
                     name, result, busy, overflow, zero, exp, (exp == '0));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mul;
        run_mul(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, "mul_ffff");
        run_mul(32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, "mul_neg");
        run_mul(32'h0000_0000, 32'h0000_0005, 32'h0000_0000, "mul_zero");
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        issue(OP_ADD, 32'd3, 32'd4);
        in_valid = 1'b1; op = OP_SUB; a = 32'd10; b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: got vld=%b res=%h rdy=%b need 1 7 0", i, out_valid, result, in_ready);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release_ready: got %b need 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd9) begin
            failures++;
            $display("FAIL hold_next: got vld=%b res=%h need 1 9", out_valid, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_drain: got vld=%b need 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul;
        int stale;
        stale = 0;
        issue(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, zero, overflow, busy} !== 4'b0000 || result !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_mul: got vld=%b z=%b ovf=%b busy=%b res=%h rdy=%b need 0s, rdy=1",
                     out_valid, zero, overflow, busy, result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL reset_stale: got %0d cycles with vld/busy need 0", stale);
        end
        issue(OP_ADD, 32'd2, 32'd3);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            failures++;
            $display("FAIL reset_after_add: got vld=%b res=%h need 1 5", out_valid, result);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = OP_AND;
        test_reset();
        test_add_overflow();
        test_compare();
        test_sub();
        test_back_to_back();
        test_mul();
        test_hold();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
